// File: rtl/padding_frame.sv
// padding_frame: streaming frame padder.
// Surrounds a DEPTH x WIDTH raster frame with PAD pixels on every side, using
// either zero fill or edge replication (chosen per frame by pad_mode at start).
// Input rows are buffered in two ping-pong line banks. The output stage emits
// (DEPTH+2*PAD) x (WIDTH+2*PAD) beats through a registered valid/ready port.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, pad_mode        frame start pulse (IDLE only), 0=zero / 1=replicate
//   in_valid/in_ready/in_data      input pixel stream, raster order
//   out_valid/out_ready/out_data   padded pixel stream, raster order
//   out_sol, out_eof       first beat of output row / last beat of frame
//   busy, frame_done       frame in progress / pulse after the eof beat
//
// state  | meaning
// IDLE   | waiting for start
// TOP    | emitting the PAD rows above the frame
// BODY   | emitting the DEPTH padded input rows
// BOTTOM | emitting the PAD rows below the frame, then waiting for eof accept
module padding_frame #(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 640,
  parameter int DEPTH      = 504,
  parameter int PAD        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pad_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sol,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int ROW_LEN = WIDTH + 2 * PAD;
  localparam int AW      = $clog2(WIDTH);
  localparam int IW      = $clog2(WIDTH) + 1;
  localparam int CW      = $clog2(ROW_LEN) + 1;
  localparam int RW      = $clog2(DEPTH + PAD) + 1;

  typedef enum logic [1:0] {IDLE, TOP, BODY, BOTTOM} state_t;

  state_t                state;
  logic                  mode_q;
  logic                  gen_done;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [RW-1:0]         in_rows;
  logic [IW-1:0]         wr_col;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            full;
  logic [DATA_WIDTH-1:0] mem       [2][WIDTH];
  logic [DATA_WIDTH-1:0] first_pix [2];
  logic [DATA_WIDTH-1:0] last_pix  [2];

  logic                  in_fire;
  logic                  wr_last;
  logic                  row_ok;
  logic                  load;
  logic                  eol;
  logic                  out_fire;
  logic                  eof_fire;
  logic                  last_body_row;
  logic                  mid;
  logic                  rd_clr;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] mid_pix;
  logic [DATA_WIDTH-1:0] next_pix;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;

  assign in_ready = busy && !full[wr_bank] && (in_rows < RW'(DEPTH));
  assign in_fire  = in_valid && in_ready;
  assign wr_last  = in_fire && (wr_col == IW'(WIDTH - 1));

  always_comb begin
    // Zero-mode TOP/BOTTOM rows need no buffered data; everything else reads
    // the current read bank, which stays full for the whole row.
    row_ok = full[rd_bank];
    if (!mode_q && (state == TOP || state == BOTTOM)) row_ok = 1'b1;
    load          = (state != IDLE) && !gen_done && row_ok && (!out_valid || out_ready);
    eol           = (col == CW'(ROW_LEN - 1));
    out_fire      = out_valid && out_ready;
    eof_fire      = out_fire && out_eof;
    last_body_row = (row == RW'(DEPTH - 1));
    mid           = (col >= CW'(PAD)) && (col < CW'(PAD + WIDTH));
    rd_idx        = mid ? AW'(col - CW'(PAD)) : '0;
    mid_pix       = mem[rd_bank][rd_idx];
    if (mid)                 next_pix = mid_pix;
    else if (col < CW'(PAD)) next_pix = first_pix[rd_bank];
    else                     next_pix = last_pix[rd_bank];
    if (!mode_q) next_pix = (state == BODY && mid) ? mid_pix : '0;
    // In replicate mode the last input row feeds BOTTOM, so its bank is
    // released only when the frame's final beat is accepted.
    rd_clr = (load && eol && state == BODY && !(mode_q && last_body_row)) ||
             (eof_fire && mode_q);
    full_set = 2'b00;
    full_clr = 2'b00;
    if (wr_last) full_set[wr_bank] = 1'b1;
    if (rd_clr)  full_clr[rd_bank] = 1'b1;
  end

  // Line storage carries no reset; validity is tracked by the full flags.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_bank][AW'(wr_col)] <= in_data;
      if (wr_col == '0) first_pix[wr_bank] <= in_data;
      if (wr_col == IW'(WIDTH - 1)) last_pix[wr_bank] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col  <= '0;
      wr_bank <= 1'b0;
      in_rows <= '0;
      full    <= 2'b00;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (in_fire) begin
        if (wr_last) begin
          wr_col  <= '0;
          wr_bank <= ~wr_bank;
          in_rows <= in_rows + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (eof_fire) in_rows <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      gen_done   <= 1'b0;
      row        <= '0;
      col        <= '0;
      rd_bank    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sol    <= 1'b0;
      out_eof    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rd_clr) rd_bank <= ~rd_bank;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= next_pix;
        out_sol   <= (col == '0);
        out_eof   <= (state == BOTTOM) && (row == RW'(PAD - 1)) && eol;
        if (eol) begin
          col <= '0;
          case (state)
            TOP: begin
              if (row == RW'(PAD - 1)) begin
                state <= BODY;
                row   <= '0;
              end else begin
                row <= row + 1'b1;
              end
            end
            BODY: begin
              if (last_body_row) begin
                state <= BOTTOM;
                row   <= '0;
              end else begin
                row <= row + 1'b1;
              end
            end
            BOTTOM: begin
              if (row == RW'(PAD - 1)) gen_done <= 1'b1;
              else                     row <= row + 1'b1;
            end
            default: ;
          endcase
        end else begin
          col <= col + 1'b1;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_sol   <= 1'b0;
        out_eof   <= 1'b0;
      end
      if (eof_fire) begin
        state      <= IDLE;
        busy       <= 1'b0;
        frame_done <= 1'b1;
        gen_done   <= 1'b0;
        row        <= '0;
        col        <= '0;
      end
      if (state == IDLE && start) begin
        state  <= TOP;
        mode_q <= pad_mode;
        busy   <= 1'b1;
        row    <= '0;
        col    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_padding_frame.sv
// tb_padding_frame: self-checking bench for padding_frame.
// Two instances: u_small (WIDTH=4, DEPTH=3, PAD=1) and u_big (WIDTH=8,
// DEPTH=6, PAD=2). Each frame's expected beats are computed from the input
// pixels and queued when the frame is launched, then popped on output beats.
module tb_padding_frame;

  typedef struct packed {
    logic [15:0] data;
    logic        sol;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        start      [2];
  logic        pad_mode   [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [15:0] in_data    [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [15:0] out_data   [2];
  logic        out_sol    [2];
  logic        out_eof    [2];
  logic        busy       [2];
  logic        frame_done [2];

  int W [2] = '{4, 8};
  int D [2] = '{3, 6};
  int P [2] = '{1, 2};

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q [$];

  always #5 clk = ~clk;

  padding_frame #(.DATA_WIDTH(16), .WIDTH(4), .DEPTH(3), .PAD(1)) u_small (
    .clk(clk), .rst(rst[0]), .start(start[0]), .pad_mode(pad_mode[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_sol(out_sol[0]), .out_eof(out_eof[0]), .busy(busy[0]),
    .frame_done(frame_done[0])
  );

  padding_frame #(.DATA_WIDTH(16), .WIDTH(8), .DEPTH(6), .PAD(2)) u_big (
    .clk(clk), .rst(rst[1]), .start(start[1]), .pad_mode(pad_mode[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_sol(out_sol[1]), .out_eof(out_eof[1]), .busy(busy[1]),
    .frame_done(frame_done[1])
  );

  // One frame on instance d. ramp: pixels base+1.. else random. poke: extra
  // start and flipped pad_mode mid-frame. rst_at>0: reset after that many beats.
  task automatic run_frame(input int d, input bit mode, input bit ramp, input int base,
                           input bit rand_in, input bit rand_out, input bit poke,
                           input int rst_at);
    int          w, h, p, n_in, n_out, idx, beats, cyc, limit, first_v, row0_cyc, rr, cc;
    logic [15:0] pix [$];
    beat_t       e, held;
    bit          stall, eof_pend, done_ok;
    w = W[d]; h = D[d]; p = P[d];
    n_in  = w * h;
    n_out = (h + 2 * p) * (w + 2 * p);
    pix.delete();
    for (int i = 0; i < n_in; i++)
      pix.push_back(ramp ? 16'(base + i + 1) : 16'($urandom_range(0, 65535)));
    exp_q.delete();
    for (int r = 0; r < h + 2 * p; r++) begin
      for (int c = 0; c < w + 2 * p; c++) begin
        rr = r - p;
        cc = c - p;
        if (mode) begin
          if (rr < 0) rr = 0;
          if (rr > h - 1) rr = h - 1;
          if (cc < 0) cc = 0;
          if (cc > w - 1) cc = w - 1;
          e.data = pix[rr * w + cc];
        end else begin
          e.data = (rr >= 0 && rr < h && cc >= 0 && cc < w) ? pix[rr * w + cc] : 16'h0;
        end
        e.sol = (c == 0);
        e.eof = (r == h + 2 * p - 1) && (c == w + 2 * p - 1);
        exp_q.push_back(e);
      end
    end

    start[d]    = 1'b1;
    pad_mode[d] = mode;
    @(negedge clk);
    start[d] = 1'b0;
    if (poke) pad_mode[d] = ~mode;
    total++;
    if (busy[d] !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start d=%0d: got %b want 1", d, busy[d]);
    end

    idx = 0; beats = 0; cyc = 0; limit = n_out * 8 + 200;
    first_v = -1; row0_cyc = -1; stall = 0; eof_pend = 0; done_ok = 0;
    held = '0;
    while (!done_ok && cyc < limit) begin
      if (eof_pend) begin
        total++;
        if (frame_done[d] !== 1'b1 || busy[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
          bad++;
          $display("FAIL frame_end d=%0d: got done=%b busy=%b valid=%b want 1 0 0",
                   d, frame_done[d], busy[d], out_valid[d]);
        end
        done_ok = 1;
      end else begin
        if (first_v < 0 && out_valid[d] === 1'b1) first_v = cyc;
        if (stall) begin
          total++;
          if (out_valid[d] !== 1'b1 || out_data[d] !== held.data ||
              out_sol[d] !== held.sol || out_eof[d] !== held.eof) begin
            bad++;
            $display("FAIL stall_hold d=%0d: got v=%b data=%h sol=%b eof=%b want v=1 data=%h sol=%b eof=%b",
                     d, out_valid[d], out_data[d], out_sol[d], out_eof[d],
                     held.data, held.sol, held.eof);
          end
        end
        total++;
        if (frame_done[d] !== 1'b0) begin
          bad++;
          $display("FAIL early_frame_done d=%0d cyc=%0d: got %b want 0", d, cyc, frame_done[d]);
        end
        if (idx == n_in) begin
          total++;
          if (in_ready[d] !== 1'b0) begin
            bad++;
            $display("FAIL in_ready_after_frame_input d=%0d: got %b want 0", d, in_ready[d]);
          end
        end
        start[d] = (poke && cyc == 3);

        if (idx < n_in) begin
          in_valid[d] = rand_in ? ($urandom_range(0, 2) != 0) : 1'b1;
          in_data[d]  = pix[idx];
          if (in_valid[d] && in_ready[d]) begin
            if (idx == w - 1) row0_cyc = cyc;
            idx++;
          end
        end else begin
          in_valid[d] = 1'b0;
        end

        out_ready[d] = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
        stall = 0;
        if (out_valid[d] === 1'b1) begin
          if (out_ready[d]) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL extra_beat d=%0d: got data=%h want no beat", d, out_data[d]);
            end else begin
              e = exp_q.pop_front();
              if (out_data[d] !== e.data || out_sol[d] !== e.sol || out_eof[d] !== e.eof) begin
                bad++;
                $display("FAIL beat%0d d=%0d: got data=%h sol=%b eof=%b want data=%h sol=%b eof=%b",
                         beats, d, out_data[d], out_sol[d], out_eof[d], e.data, e.sol, e.eof);
              end
              if (e.eof) eof_pend = 1;
            end
            beats++;
          end else begin
            stall     = 1;
            held.data = out_data[d];
            held.sol  = out_sol[d];
            held.eof  = out_eof[d];
          end
        end

        if (rst_at > 0 && beats == rst_at) begin
          rst[d]      = 1'b1;
          in_valid[d] = 1'b0;
          @(negedge clk);
          total++;
          if (out_valid[d] !== 1'b0 || out_data[d] !== 16'h0 || out_sol[d] !== 1'b0 ||
              out_eof[d] !== 1'b0 || busy[d] !== 1'b0 || frame_done[d] !== 1'b0 ||
              in_ready[d] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid d=%0d: got v=%b data=%h sol=%b eof=%b busy=%b done=%b rdy=%b want all 0",
                     d, out_valid[d], out_data[d], out_sol[d], out_eof[d], busy[d],
                     frame_done[d], in_ready[d]);
          end
          rst[d] = 1'b0;
          exp_q.delete();
          @(negedge clk);
          return;
        end
      end
      if (!done_ok) begin
        @(negedge clk);
        cyc++;
      end
    end
    start[d]    = 1'b0;
    in_valid[d] = 1'b0;

    total++;
    if (!done_ok) begin
      bad++;
      $display("FAIL timeout d=%0d: got %0d beats in %0d cycles want eof", d, beats, cyc);
    end
    total++;
    if (beats != n_out || exp_q.size() != 0) begin
      bad++;
      $display("FAIL beat_count d=%0d: got %0d want %0d", d, beats, n_out);
    end
    total++;
    if (!mode && (first_v < 0 || first_v > 2)) begin
      bad++;
      $display("FAIL zero_latency d=%0d: got %0d want <=2", d, first_v);
    end else if (mode && (first_v < 0 || row0_cyc < 0 || first_v - row0_cyc > 3)) begin
      bad++;
      $display("FAIL rep_latency d=%0d: got %0d want <=3", d, first_v - row0_cyc);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; pad_mode[d] = 1'b0; in_valid[d] = 1'b0;
      in_data[d] = 16'h0; out_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_valid[d] !== 1'b0 || out_data[d] !== 16'h0 || out_sol[d] !== 1'b0 ||
          out_eof[d] !== 1'b0 || busy[d] !== 1'b0 || frame_done[d] !== 1'b0 ||
          in_ready[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs d=%0d: got v=%b data=%h busy=%b rdy=%b want all 0",
                 d, out_valid[d], out_data[d], busy[d], in_ready[d]);
      end
      rst[d] = 1'b0;
    end
    in_valid[0] = 1'b1;
    in_data[0]  = 16'hdead;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
        bad++;
        $display("FAIL idle_no_accept: got rdy=%b valid=%b want 0 0", in_ready[0], out_valid[0]);
      end
    end
    in_valid[0] = 1'b0;
  endtask

  task automatic test_zero_small();
    run_frame(0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_replicate_small();
    run_frame(0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random_stalls();
    run_frame(1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    run_frame(1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    run_frame(1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_start_ignored();
    run_frame(1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 0);
    pad_mode[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (frame_done[1] !== 1'b0 || busy[1] !== 1'b0) begin
        bad++;
        $display("FAIL single_frame_done: got done=%b busy=%b want 0 0", frame_done[1], busy[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_frame(1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 40);
    run_frame(1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(1, 1'b0, 1'b1, 0,    1'b0, 1'b0, 1'b0, 0);
    run_frame(1, 1'b0, 1'b1, 1000, 1'b0, 1'b0, 1'b0, 0);
    run_frame(1, 1'b1, 1'b1, 2000, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_zero_small();
    test_replicate_small();
    test_random_stalls();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
